// File: rtl/epcs16_flash_arbiter_if.sv
// epcs16_flash_arbiter_if
//   Bundles the requester-side command/handshake signals and the single
//   EPCS16 driver command port shared by epcs16_flash_arbiter.
//
//   Requester side (N requesters, requester i owns slice i):
//     Request      N     level request for the driver mutex
//     Grant        N     one-hot registered grant
//     Sector_In    5*N   sector, bits [5i+4:5i]
//     Page_In      8*N   page, bits [8i+7:8i]
//     ReadPage_In  N     read strobe
//     Address_In   8*N   buffer address, bits [8i+7:8i]
//     Busy_Out     N     driver busy as seen by each requester
//   Driver side:
//     EPCS16_Sector/Page/ReadPage/Address  command to driver
//     EPCS16_Busy                          busy from driver
//   Status:
//     Timeout      one-cycle pulse on forced release
//
//   modport master : requesters + driver model (drive requests, read grant)
//   modport slave  : the arbiter
interface epcs16_flash_arbiter_if #(
    parameter int N = 3
);
    logic [N-1:0]   Request;
    logic [N-1:0]   Grant;
    logic [5*N-1:0] Sector_In;
    logic [8*N-1:0] Page_In;
    logic [N-1:0]   ReadPage_In;
    logic [8*N-1:0] Address_In;
    logic [N-1:0]   Busy_Out;
    logic [4:0]     EPCS16_Sector;
    logic [7:0]     EPCS16_Page;
    logic           EPCS16_ReadPage;
    logic [7:0]     EPCS16_Address;
    logic           EPCS16_Busy;
    logic           Timeout;

    modport master (
        output Request, Sector_In, Page_In, ReadPage_In, Address_In, EPCS16_Busy,
        input  Grant, Busy_Out, EPCS16_Sector, EPCS16_Page, EPCS16_ReadPage,
               EPCS16_Address, Timeout
    );

    modport slave (
        input  Request, Sector_In, Page_In, ReadPage_In, Address_In, EPCS16_Busy,
        output Grant, Busy_Out, EPCS16_Sector, EPCS16_Page, EPCS16_ReadPage,
               EPCS16_Address, Timeout
    );
endinterface

// File: rtl/epcs16_flash_arbiter.sv
// epcs16_flash_arbiter
//   Round-robin mutex arbiter and command mux sharing one EPCS16 page
//   read/program driver between N requesters (read cache, writer/eraser,
//   configuration loader, ...). The owner's sector/page/strobe/address go to
//   the driver; only the owner sees the real driver busy, everyone else sees
//   busy=1. After a release the arbiter waits for the driver to go idle
//   before granting again, so no command is ever switched mid-transfer.
//
//   Ports:
//     Clk     system clock (<= 40 MHz)
//     nReset  asynchronous active-low reset
//     bus     epcs16_flash_arbiter_if.slave (requests, grants, command mux,
//             driver busy, Timeout)
//
//   Parameters:
//     N        number of requesters, 2..8
//     TIMEOUT  idle-owner cycles before forced release
//
//   Optional build macro EPCS16_ARB_TIMEOUT_EN: enables the idle-owner
//   watchdog, the per-requester mask and the Timeout pulse. Without it the
//   owner keeps the grant until it drops Request and Timeout is tied low.
module epcs16_flash_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 65535
) (
    input logic                 Clk,
    input logic                 nReset,
    epcs16_flash_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

    state_t        state;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] last;
    logic [N-1:0]  candidates;
    logic          found;
    logic [IW-1:0] pick;

`ifdef EPCS16_ARB_TIMEOUT_EN
    logic [N-1:0]  mask;
    logic [15:0]   idle_cnt;
    logic          timeout_q;

    assign candidates  = bus.Request & ~mask;
    assign bus.Timeout = timeout_q;
`else
    logic [31:0]   unused_timeout;

    assign unused_timeout = 32'(TIMEOUT);
    assign candidates     = bus.Request;
    assign bus.Timeout    = 1'b0;
`endif

    assign bus.Grant = grant_q;

    // Round-robin search starting just after the last owner. Offsets are
    // scanned from farthest to nearest so the nearest hit is written last.
    always_comb begin : rr_search
        logic [IW:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int off = N; off >= 1; off--) begin
            idx = {1'b0, last} + (IW+1)'(off);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (candidates[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    // Ownership FSM. While OWNED, 'last' doubles as the owner index.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            grant_q   <= '0;
            last      <= IW'(N - 1);
`ifdef EPCS16_ARB_TIMEOUT_EN
            mask      <= '0;
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef EPCS16_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
            mask      <= mask & bus.Request;
`endif
            case (state)
                IDLE: begin
                    if (!bus.EPCS16_Busy && found) begin
                        grant_q  <= N'(1) << pick;
                        last     <= pick;
                        state    <= OWNED;
`ifdef EPCS16_ARB_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                OWNED: begin
                    if (!bus.Request[last]) begin
                        grant_q <= '0;
                        state   <= DRAIN;
                    end
`ifdef EPCS16_ARB_TIMEOUT_EN
                    else if (bus.EPCS16_Busy || bus.ReadPage_In[last]) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == 16'(TIMEOUT - 1)) begin
                        // Owner sat idle too long: evict it and keep it out
                        // until it lets go of Request.
                        grant_q    <= '0;
                        mask[last] <= 1'b1;
                        timeout_q  <= 1'b1;
                        state      <= DRAIN;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
`endif
                end
                DRAIN: begin
                    if (!bus.EPCS16_Busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command mux from the registered grant; no grant drives all zeros and
    // every requester except the owner sees the driver as busy.
    always_comb begin
        bus.EPCS16_Sector   = '0;
        bus.EPCS16_Page     = '0;
        bus.EPCS16_ReadPage = 1'b0;
        bus.EPCS16_Address  = '0;
        bus.Busy_Out        = '1;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                bus.EPCS16_Sector   = bus.EPCS16_Sector | bus.Sector_In[5*i +: 5];
                bus.EPCS16_Page     = bus.EPCS16_Page | bus.Page_In[8*i +: 8];
                bus.EPCS16_ReadPage = bus.EPCS16_ReadPage | bus.ReadPage_In[i];
                bus.EPCS16_Address  = bus.EPCS16_Address | bus.Address_In[8*i +: 8];
                bus.Busy_Out[i]     = bus.EPCS16_Busy;
            end
        end
    end
endmodule

// File: tb/tb_epcs16_flash_arbiter.sv
// tb_epcs16_flash_arbiter
//   Self-checking bench for epcs16_flash_arbiter (N=3, TIMEOUT=16): a
//   hand-derived vector table, hand-written round-robin / reset / watchdog
//   sequences, and a randomized run against a behavioural model. Honours
//   EPCS16_ARB_TIMEOUT_EN the same way the design does.
module tb_epcs16_flash_arbiter;
    localparam int N       = 3;
    localparam int TIMEOUT = 16;

    logic Clk = 1'b0;
    logic nReset;

    epcs16_flash_arbiter_if #(.N(N)) bus();

    epcs16_flash_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns the driver, who owned it last, whether a
    // release is still waiting for the driver to be seen idle.
    int           mOwner;
    int           mLast;
    int           mIdle;
    bit           mWaitIdle;
    bit           mTimeout;
    logic [N-1:0] mMask;

    typedef struct {
        logic [N-1:0] req;
        logic         busy;
        logic [N-1:0] expGrant;
        logic [N-1:0] expBusyOut;
        bit           chkSlice0;
    } vec_t;

    vec_t         tbl [14];
    logic [N-1:0] rrExp [4];
    logic [N-1:0] reqv;
    logic [N-1:0] g;
    int           got;
    int           held;
    int           gap;
    bit           found;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mOwner    = -1;
        mLast     = N - 1;
        mIdle     = 0;
        mWaitIdle = 1'b0;
        mTimeout  = 1'b0;
        mMask     = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        logic [N-1:0] nextMask;
        mTimeout = 1'b0;
        nextMask = mMask & bus.Request;
        if (mOwner >= 0) begin
            if (!bus.Request[mOwner]) begin
                mOwner    = -1;
                mWaitIdle = 1'b1;
            end
`ifdef EPCS16_ARB_TIMEOUT_EN
            else begin
                if (bus.EPCS16_Busy || bus.ReadPage_In[mOwner]) mIdle = 0;
                else mIdle++;
                if (mIdle == TIMEOUT) begin
                    nextMask[mOwner] = 1'b1;
                    mTimeout  = 1'b1;
                    mOwner    = -1;
                    mWaitIdle = 1'b1;
                end
            end
`endif
        end else if (mWaitIdle) begin
            if (!bus.EPCS16_Busy) mWaitIdle = 1'b0;
        end else if (!bus.EPCS16_Busy) begin
            for (int off = 1; off <= N; off++) begin
                int c;
                c = (mLast + off) % N;
                if (mOwner < 0 && bus.Request[c] && !mMask[c]) begin
                    mOwner = c;
                    mLast  = c;
                    mIdle  = 0;
                end
            end
        end
`ifdef EPCS16_ARB_TIMEOUT_EN
        mMask = nextMask;
`else
        mMask = '0;
`endif
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic busy, input logic [N-1:0] rp);
        bus.Request     = req;
        bus.EPCS16_Busy = busy;
        bus.ReadPage_In = rp;
        bus.Sector_In   = (5*N)'($urandom);
        bus.Page_In     = (8*N)'($urandom);
        bus.Address_In  = (8*N)'($urandom);
    endtask

    task automatic tick();
        modelStep();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0] eGrant;
        logic [N-1:0] eBusyOut;
        logic [4:0]   eSector;
        logic [7:0]   ePage;
        logic [7:0]   eAddr;
        logic         eRp;
        eGrant  = '0;
        eSector = '0;
        ePage   = '0;
        eAddr   = '0;
        eRp     = 1'b0;
        for (int i = 0; i < N; i++) begin
            eBusyOut[i] = (i == mOwner) ? bus.EPCS16_Busy : 1'b1;
        end
        if (mOwner >= 0) begin
            eGrant[mOwner] = 1'b1;
            eSector = bus.Sector_In[5*mOwner +: 5];
            ePage   = bus.Page_In[8*mOwner +: 8];
            eAddr   = bus.Address_In[8*mOwner +: 8];
            eRp     = bus.ReadPage_In[mOwner];
        end
        compare({tag, "_grant"},    32'(bus.Grant),           32'(eGrant));
        compare({tag, "_busyout"},  32'(bus.Busy_Out),        32'(eBusyOut));
        compare({tag, "_sector"},   32'(bus.EPCS16_Sector),   32'(eSector));
        compare({tag, "_page"},     32'(bus.EPCS16_Page),     32'(ePage));
        compare({tag, "_address"},  32'(bus.EPCS16_Address),  32'(eAddr));
        compare({tag, "_readpage"}, 32'(bus.EPCS16_ReadPage), 32'(eRp));
        compare({tag, "_timeout"},  32'(bus.Timeout),         32'(mTimeout));
    endtask

    task automatic doReset();
        nReset = 1'b0;
        modelReset();
        applyStimulus('0, 1'b0, '0);
        #1;
        compare("reset_async_grant", 32'(bus.Grant), 32'h0);
        repeat (2) @(posedge Clk);
        #1;
        nReset = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{3'b001, 1'b0, 3'b001, 3'b110, 1'b1};
        tbl[1]  = '{3'b001, 1'b0, 3'b001, 3'b110, 1'b1};
        tbl[2]  = '{3'b000, 1'b0, 3'b000, 3'b111, 1'b0};
        tbl[3]  = '{3'b010, 1'b0, 3'b000, 3'b111, 1'b0};
        tbl[4]  = '{3'b010, 1'b0, 3'b010, 3'b101, 1'b0};
        tbl[5]  = '{3'b010, 1'b1, 3'b010, 3'b111, 1'b0};
        tbl[6]  = '{3'b100, 1'b1, 3'b000, 3'b111, 1'b0};
        tbl[7]  = '{3'b100, 1'b1, 3'b000, 3'b111, 1'b0};
        tbl[8]  = '{3'b100, 1'b1, 3'b000, 3'b111, 1'b0};
        tbl[9]  = '{3'b100, 1'b1, 3'b000, 3'b111, 1'b0};
        tbl[10] = '{3'b100, 1'b0, 3'b000, 3'b111, 1'b0};
        tbl[11] = '{3'b100, 1'b0, 3'b100, 3'b011, 1'b0};
        tbl[12] = '{3'b000, 1'b0, 3'b000, 3'b111, 1'b0};
        tbl[13] = '{3'b000, 1'b0, 3'b000, 3'b111, 1'b0};
        rrExp[0] = 3'b001;
        rrExp[1] = 3'b010;
        rrExp[2] = 3'b100;
        rrExp[3] = 3'b001;

        nReset = 1'b1;
        applyStimulus('0, 1'b0, '0);
        modelReset();
        #2;

        $display("[TB] reset state");
        doReset();
        checkOutput("reset");
        compare("reset_busyout_all", 32'(bus.Busy_Out), 32'h7);
        compare("reset_timeout", 32'(bus.Timeout), 32'h0);

        $display("[TB] vector table");
        for (int r = 0; r < 14; r++) begin
            applyStimulus(tbl[r].req, tbl[r].busy, '0);
            tick();
            checkOutput("tbl");
            compare($sformatf("tbl%0d_grant", r), 32'(bus.Grant), 32'(tbl[r].expGrant));
            compare($sformatf("tbl%0d_busyout", r), 32'(bus.Busy_Out), 32'(tbl[r].expBusyOut));
            if (tbl[r].chkSlice0) begin
                compare("slice0_sector", 32'(bus.EPCS16_Sector), 32'(bus.Sector_In[4:0]));
                compare("slice0_page", 32'(bus.EPCS16_Page), 32'(bus.Page_In[7:0]));
                compare("slice0_address", 32'(bus.EPCS16_Address), 32'(bus.Address_In[7:0]));
            end
        end

        $display("[TB] round-robin with all requesting");
        doReset();
        reqv = 3'b111;
        got  = 0;
        held = 0;
        gap  = 0;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            applyStimulus(reqv, 1'b0, '0);
            tick();
            checkOutput("rr");
            g = bus.Grant;
            if (g != '0) begin
                if (held == 0) begin
                    compare($sformatf("rr_order%0d", got), 32'(g), 32'(rrExp[got]));
                    if (got > 0) compare("rr_gap_ge2", 32'(gap >= 2), 32'h1);
                    got++;
                end
                held++;
                gap = 0;
                if (held == 5) reqv = 3'b111 & ~g;
            end else begin
                held = 0;
                gap++;
                reqv = 3'b111;
            end
        end
        compare("rr_budget_grants", 32'(got), 32'h4);

        $display("[TB] reset during read");
        doReset();
        applyStimulus(3'b010, 1'b0, 3'b010);
        tick();
        checkOutput("midrst_pre");
        compare("midrst_grant_pre", 32'(bus.Grant), 32'h2);
        compare("midrst_readpage_pre", 32'(bus.EPCS16_ReadPage), 32'h1);
        #2;
        nReset = 1'b0;
        modelReset();
        #1;
        compare("midrst_grant", 32'(bus.Grant), 32'h0);
        compare("midrst_readpage", 32'(bus.EPCS16_ReadPage), 32'h0);
        compare("midrst_sector", 32'(bus.EPCS16_Sector), 32'h0);
        @(posedge Clk);
        #1;
        nReset = 1'b1;
        applyStimulus(3'b111, 1'b0, '0);
        tick();
        checkOutput("midrst_post");
        compare("midrst_first_owner", 32'(bus.Grant), 32'h1);

        $display("[TB] idle owner hold");
        doReset();
        applyStimulus(3'b100, 1'b0, '0);
        tick();
        checkOutput("to");
        compare("to_first_grant", 32'(bus.Grant), 32'h4);
`ifdef EPCS16_ARB_TIMEOUT_EN
        for (int c = 1; c <= TIMEOUT; c++) begin
            applyStimulus(3'b100, 1'b0, '0);
            tick();
            checkOutput("to_hold");
            if (c < TIMEOUT) begin
                compare("to_held", 32'(bus.Grant), 32'h4);
            end else begin
                compare("to_release", 32'(bus.Grant), 32'h0);
                compare("to_pulse", 32'(bus.Timeout), 32'h1);
            end
        end
        applyStimulus(3'b100, 1'b0, '0);
        tick();
        checkOutput("to_after");
        compare("to_pulse_end", 32'(bus.Timeout), 32'h0);
        repeat (5) begin
            applyStimulus(3'b100, 1'b0, '0);
            tick();
            checkOutput("to_masked");
            compare("to_masked_grant", 32'(bus.Grant), 32'h0);
        end
        applyStimulus(3'b000, 1'b0, '0);
        tick();
        checkOutput("to_drop");
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            applyStimulus(3'b100, 1'b0, '0);
            tick();
            checkOutput("to_rereq");
            if (bus.Grant == 3'b100) found = 1'b1;
        end
        compare("to_regrant", 32'(found), 32'h1);
`else
        repeat (40) begin
            applyStimulus(3'b100, 1'b0, '0);
            tick();
            checkOutput("hold");
            compare("hold_grant", 32'(bus.Grant), 32'h4);
            compare("hold_timeout", 32'(bus.Timeout), 32'h0);
        end
`endif

        $display("[TB] randomized run");
        reqv = '0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) reqv[b] = ~reqv[b];
            end
            applyStimulus(reqv, ($urandom_range(0, 9) < 3), N'($urandom) & N'($urandom));
            tick();
            checkOutput("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/epcs16_flash_arbiter.md
Name: epcs16_flash_arbiter

Overview:
- Mutex arbiter and command mux that shares one EPCS16 page-read/program driver between N requesters.
- Typical requesters: the EPCS16 read cache, the flash writer/eraser and the configuration loader.
- Grants one requester at a time, round-robin.
- Routes the granted requester's sector/page/strobe/address to the driver and its Busy back to that requester.
- Sits between the requester blocks and the single EPCS16 driver instance.

Parameters:
- N, 3, number of requesters (2..8).
- TIMEOUT, 65535, idle-hold cycles before forced release (used only with the optional feature).

Ports:
- Clk  in  1  system clock, max 40 MHz
- nReset  in  1  asynchronous, active-low reset
- Request  in  N  per-requester mutex request, level
- Grant  out  N  one-hot grant, registered
- Sector_In  in  5*N  requester i uses bits [5i+4:5i]
- Page_In  in  8*N  requester i uses bits [8i+7:8i]
- ReadPage_In  in  N  per-requester read strobe
- Address_In  in  8*N  requester i uses bits [8i+7:8i], buffer address
- Busy_Out  out  N  per-requester view of driver busy
- EPCS16_Sector  out  5  to driver
- EPCS16_Page  out  8  to driver
- EPCS16_ReadPage  out  1  to driver
- EPCS16_Address  out  8  to driver
- EPCS16_Busy  in  1  from driver
- Timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset values (async, nReset low): Grant=0, Timeout=0, state=IDLE, Last=N-1 so requester 0 has first priority, idle counter=0, mask=0.
- Output mux (combinational from the registered Grant):
  - EPCS16_* = granted requester's slice.
  - With no grant: Sector=0, Page=0, ReadPage=0, Address=0.
  - Busy_Out[i] = Grant[i] ? EPCS16_Busy : 1. Ungranted requesters always see busy.
- State IDLE:
  - Candidates = Request & ~mask.
  - Search round-robin starting at Last+1, wrapping at N-1 back to 0.
  - First candidate found is k: set Grant to one-hot(k), Last=k, go to OWNED.
  - Grant rises the cycle after Request is first sampled high, i.e. 1-cycle latency.
  - If the driver is busy (EPCS16_Busy=1), stay in IDLE; no grant is issued.
- State OWNED:
  - Grant holds.
  - Request[k] falls: drop Grant immediately (next edge) and go to DRAIN.
  - Request on other requesters is ignored until release.
- State DRAIN:
  - Wait until EPCS16_Busy=0, then go to IDLE.
  - The earliest new grant is the cycle after that; this guarantees no command is issued mid-transfer.
- Simultaneous events:
  - Release and other requests in the same cycle: the next owner is the next index after k in round-robin order.
  - Requests arriving during DRAIN are served in the order above once IDLE is reached.
- Mask:
  - Bit i sets only on forced release (see optional feature).
  - Bit i clears when Request[i]=0.
- Reset mid-operation: Grant drops asynchronously and all command outputs go to 0. A driver read in progress is abandoned.
- Single requester: re-granted each time it re-requests, with at least 2 cycles between grants (DRAIN + IDLE).

Optional Feature:
- Macro: EPCS16_ARB_TIMEOUT_EN.
- Defined:
  - In OWNED, a 16-bit counter counts cycles where EPCS16_Busy=0 and ReadPage_In[k]=0.
  - The counter clears on any cycle with busy or strobe.
  - When the count reaches TIMEOUT: Grant drops, mask[k] is set, Timeout pulses 1 cycle, go to DRAIN.
  - A masked requester is not granted again until it deasserts Request.
- Not defined: no counter, no mask logic, Timeout tied 0.

Test Plan (N=3, TIMEOUT=16):
- Reset, then Request=001 -> Grant=001 one cycle later. EPCS16_Sector/Page/Address follow slice 0. Busy_Out=110 while EPCS16_Busy=0.
- Request=111 held, each owner releases after 5 cycles -> grant order 001,010,100,001, with ≥2 cycles of Grant=000 between owners.
- Owner 1 drops Request while EPCS16_Busy=1 for 4 more cycles -> Grant=000 the next cycle, and no new grant until the cycle after Busy falls, even with Request[2]=1.
- nReset pulsed low during OWNED with ReadPage=1 -> Grant=000, EPCS16_ReadPage=0 immediately. After reset, requester 0 is granted first.
- With EPCS16_ARB_TIMEOUT_EN: owner 2 holds 16 cycles idle -> Timeout pulses, Grant drops. Request[2] still high is not re-granted. After Request[2] drops and re-rises -> granted again.
- Without the macro: same stimulus -> grant held indefinitely, Timeout stays 0.
